// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

  // Per-slot phase: dark dead-time first, then the digit is driven.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low segment pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Per-bit anode level meaning "digit not selected" (anodes are active-low).
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/SevenSeg.sv
// Hex nibble to seven-segment decoder, segments {a,b,c,d,e,f,g}, active-high.
// Latency: combinational.
// Backpressure: none.
module SevenSeg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    seg_o = 7'h00;
    case (nibble_i)
      4'h0: seg_o = 7'h7E;
      4'h1: seg_o = 7'h30;
      4'h2: seg_o = 7'h6D;
      4'h3: seg_o = 7'h79;
      4'h4: seg_o = 7'h33;
      4'h5: seg_o = 7'h5B;
      4'h6: seg_o = 7'h5F;
      4'h7: seg_o = 7'h70;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h7B;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h1F;
      4'hC: seg_o = 7'h4E;
      4'hD: seg_o = 7'h3D;
      4'hE: seg_o = 7'h4F;
      4'hF: seg_o = 7'h47;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of N_DIGITS common-anode digits through one shared decoder.
// Latency: outputs registered, one cycle behind cnt/idx; loads applied at next frame boundary.
// Backpressure: none; a later load overwrites pending data (last write wins).
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    lz_en,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [31:0]      BLANK_U  = 32'(BLANK_CYCLES);
  // With no dead-time every slot starts directly in SHOW.
  localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  // Pending (staged) display set.
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q,  pend_dp_d;
  logic [N_DIGITS-1:0]   pend_en_q,  pend_en_d;
  logic                  pend_lz_q,  pend_lz_d;
  logic                  pending_q,  pending_d;

  // Active (displayed) set.
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d;
  logic [N_DIGITS-1:0]   act_dp_q,  act_dp_d;
  logic [N_DIGITS-1:0]   act_en_q,  act_en_d;
  logic                  act_lz_q,  act_lz_d;

  // Scan position.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_t      state_q, state_d;

  // Registered pin drivers.
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q;

  logic                slot_end;
  logic                boundary;
  logic [3:0]          cur_nibble;
  logic [6:0]          seg_hi;
  logic [N_DIGITS-1:0] lz_sup;
  logic                zero_above;
  logic                digit_dark;

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);

  // Slot counter and digit index advance; index wraps at the last digit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Slot phase FSM: dead-time for the first BLANK_CYCLES, then drive the digit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK: begin
        if (slot_end) begin
          state_d = SLOT_START;
        end else if ((32'(cnt_q) + 32'd1) >= BLANK_U) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (slot_end) begin
          state_d = SLOT_START;
        end
      end
      default: state_d = SLOT_START;
    endcase
  end

  // Staging: the boundary copy sees the pre-load pending set, so a load on the
  // boundary cycle is kept for the following frame.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    pend_lz_d  = pend_lz_q;
    pending_d  = pending_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    act_lz_d   = act_lz_q;
    if (boundary && pending_q) begin
      act_val_d = pend_val_q;
      act_dp_d  = pend_dp_q;
      act_en_d  = pend_en_q;
      act_lz_d  = pend_lz_q;
      pending_d = 1'b0;
    end
    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
      pend_en_d  = digit_en;
      pend_lz_d  = lz_en;
      pending_d  = 1'b1;
    end
  end

  // Leading-zero mask: digit i is suppressed when it and every digit above it are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_sup     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (act_val_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        lz_sup[i] = act_lz_q & zero_above;
      end
    end
  end

  assign cur_nibble = act_val_q[{idx_q, 2'b00} +: 4];
  assign digit_dark = ~act_en_q[idx_q] | lz_sup[idx_q];

  SevenSeg u_seven_seg (
    .nibble_i (cur_nibble),
    .seg_o    (seg_hi)
  );

  // Pin values for the current position; a dark digit keeps its anode selected.
  always_comb begin
    an_d  = {N_DIGITS{AN_OFF}};
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == SHOW) begin
      an_d[idx_q] = ~AN_OFF;
      if (!digit_dark) begin
        seg_d = ~seg_hi;
        dp_d  = ~act_dp_q[idx_q];
      end
    end
  end

  // Data registers; reset discards anything staged.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      pend_lz_q  <= 1'b0;
      pending_q  <= 1'b0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      act_lz_q   <= 1'b0;
    end else begin
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      pend_lz_q  <= pend_lz_d;
      pending_q  <= pending_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      act_lz_q   <= act_lz_d;
    end
  end

  // Scan position and FSM state register; reset restarts at digit 0, cycle 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= SLOT_START;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Output register stage so all pins change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= {N_DIGITS{AN_OFF}};
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= boundary;
    end
  end

  assign anodes     = an_q;
  assign segments   = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a time-based reference model.
// Latency: model predicts registered outputs one cycle after each scan position.
// Backpressure: none.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_en;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_done;
  logic        pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Active-high glyphs {a..g} for hex digits 0..F.
  logic [6:0] HEX_ON [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state: m_t counts cycles since reset release.
  int          m_t;
  logic [15:0] m_pv, m_av;
  logic [3:0]  m_pdp, m_adp, m_pen, m_aen;
  logic        m_plz, m_alz, m_pending;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd, exp_pend;

  logic [6:0]  seg_seen [4];
  logic [3:0]  dp_seen;
  logic [3:0]  an_seen;

  display_scan_ctrl #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_en      (lz_en),
    .anodes     (anodes),
    .segments   (segments),
    .dp         (dp),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] dut_vec();
    return {anodes, segments, dp, frame_done, pending};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {exp_an, exp_seg, exp_dp, exp_fd, exp_pend};
  endfunction

  // Predicts the outputs produced by the edge that just happened.
  task automatic model_edge();
    int pos, slot, phase;
    bit bnd, dark, upper_zero;
    if (reset) begin
      m_t = 0;
      m_pv = '0; m_av = '0; m_pdp = '0; m_adp = '0; m_pen = '0; m_aen = '0;
      m_plz = 1'b0; m_alz = 1'b0; m_pending = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0; exp_pend = 1'b0;
      return;
    end
    pos   = m_t % FRAME;
    slot  = pos / RD;
    phase = pos % RD;
    bnd   = (pos == FRAME - 1);
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    if (phase >= BC) begin
      exp_an     = 4'hF & ~(4'd1 << slot);
      upper_zero = ((m_av >> (4 * slot)) == 16'h0);
      dark       = !m_aen[slot] || (m_alz && slot >= 1 && upper_zero);
      if (!dark) begin
        exp_seg = ~HEX_ON[m_av[4*slot +: 4]];
        exp_dp  = ~m_adp[slot];
      end
    end
    exp_fd = bnd;
    if (bnd && m_pending) begin
      m_av = m_pv; m_adp = m_pdp; m_aen = m_pen; m_alz = m_plz;
      m_pending = 1'b0;
    end
    if (load) begin
      m_pv = value_in; m_pdp = dp_in; m_pen = digit_en; m_plz = lz_en;
      m_pending = 1'b1;
    end
    exp_pend = m_pending;
    m_t++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] e, input logic lz);
    value_in = v; dp_in = d; digit_en = e; lz_en = lz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advances until the next edge will be at frame position p (model-timed, bounded).
  task automatic wait_pos(input int p);
    for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) tick();
  endtask

  task automatic record_digit();
    for (int k = 0; k < N; k++) begin
      if (!anodes[k]) begin
        seg_seen[k] = segments;
        dp_seen[k]  = dp;
      end
    end
    an_seen = an_seen | ~anodes;
  endtask

  task automatic clear_seen();
    for (int k = 0; k < N; k++) seg_seen[k] = 7'h55;
    dp_seen = 4'hA;
    an_seen = 4'h0;
  endtask

  task automatic test_reset();
    int cyc;
    bit found;
    reset = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; digit_en = '0; lz_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_values cyc=%0d got=%h exp=%h", i, dut_vec(), {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
      end
    end
    reset = 1'b0;
    cyc = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      cyc++;
      if (anodes === 4'b1110) found = 1;
    end
    n_tests++;
    if (!found || cyc != 3) begin
      n_fail++;
      $display("FAIL reset_first_digit got=%0d cycles (found=%0d) exp=3", cyc, found);
    end
  endtask

  task automatic test_scan();
    int last_fd;
    do_load(16'h1234, 4'h0, 4'hF, 1'b0);
    last_fd = -1;
    clear_seen();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL scan t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          n_tests++;
          if (m_t - last_fd != FRAME) begin
            n_fail++;
            $display("FAIL frame_period got=%0d exp=%0d", m_t - last_fd, FRAME);
          end
        end
        last_fd = m_t;
      end
      if (!pending) record_digit();
    end
    n_tests++;
    if ({seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3]} !== {~7'h33, ~7'h79, ~7'h6D, ~7'h30}) begin
      n_fail++;
      $display("FAIL scan_glyphs got=%h_%h_%h_%h exp=%h_%h_%h_%h", seg_seen[0], seg_seen[1],
               seg_seen[2], seg_seen[3], ~7'h33, ~7'h79, ~7'h6D, ~7'h30);
    end
  endtask

  task automatic test_tear_free();
    bit seen_fd;
    wait_pos(2 * RD + BC + 1);
    do_load(16'hABCD, 4'h0, 4'hF, 1'b0);
    seen_fd = 0;
    for (int i = 0; i < FRAME + 2 && !seen_fd; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL tear_model t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
      end
      if (frame_done) begin
        seen_fd = 1;
      end else begin
        n_tests++;
        if (pending !== 1'b1) begin
          n_fail++;
          $display("FAIL tear_pending got=%b exp=1", pending);
        end
        if (anodes === 4'b0111) begin
          n_tests++;
          if (segments !== ~7'h30) begin
            n_fail++;
            $display("FAIL tear_old_digit3 got=%h exp=%h", segments, ~7'h30);
          end
        end
      end
    end
    n_tests++;
    if (!seen_fd) begin
      n_fail++;
      $display("FAIL tear_boundary got=no frame_done exp=frame_done");
    end
    clear_seen();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      record_digit();
    end
    n_tests++;
    if ({seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3]} !== {~7'h3D, ~7'h4E, ~7'h1F, ~7'h77}) begin
      n_fail++;
      $display("FAIL tear_new_frame got=%h_%h_%h_%h exp=%h_%h_%h_%h", seg_seen[0], seg_seen[1],
               seg_seen[2], seg_seen[3], ~7'h3D, ~7'h4E, ~7'h1F, ~7'h77);
    end
  endtask

  task automatic test_collision();
    do_load(16'h9876, 4'h0, 4'hF, 1'b0);
    wait_pos(FRAME - 1);
    value_in = 16'h5555; load = 1'b1;
    tick();
    load = 1'b0;
    n_tests++;
    if ({frame_done, pending} !== 2'b11) begin
      n_fail++;
      $display("FAIL collision_boundary got fd/pend=%b%b exp=11", frame_done, pending);
    end
    clear_seen();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL collision_model t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
      end
      if (i < FRAME - 1) record_digit();
    end
    n_tests++;
    if ({seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3]} !== {~7'h5F, ~7'h70, ~7'h7F, ~7'h7B}) begin
      n_fail++;
      $display("FAIL collision_first got=%h_%h_%h_%h exp=%h_%h_%h_%h", seg_seen[0], seg_seen[1],
               seg_seen[2], seg_seen[3], ~7'h5F, ~7'h70, ~7'h7F, ~7'h7B);
    end
    clear_seen();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      record_digit();
    end
    n_tests++;
    if ({seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3]} !== {4{~7'h5B}}) begin
      n_fail++;
      $display("FAIL collision_second got=%h_%h_%h_%h exp=%h x4", seg_seen[0], seg_seen[1],
               seg_seen[2], seg_seen[3], ~7'h5B);
    end
  endtask

  task automatic test_blanking();
    for (int pass = 0; pass < 2; pass++) begin
      do_load(pass == 0 ? 16'h0070 : 16'h0000, 4'b0001, 4'hF, 1'b1);
      for (int i = 0; i < FRAME + 1 && pending; i++) tick();
      clear_seen();
      for (int i = 0; i < FRAME; i++) begin
        tick();
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL blank_model p=%0d t=%0d got=%h exp=%h", pass, m_t, dut_vec(), exp_vec());
        end
        record_digit();
      end
      n_tests++;
      if ({an_seen, seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3], dp_seen} !==
          {4'hF, ~7'h7E, (pass == 0) ? ~7'h70 : 7'h7F, 7'h7F, 7'h7F, 4'b1110}) begin
        n_fail++;
        $display("FAIL blank_digits p=%0d got an=%b seg=%h_%h_%h_%h dp=%b", pass, an_seen,
                 seg_seen[0], seg_seen[1], seg_seen[2], seg_seen[3], dp_seen);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FRAME; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        value_in = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
        lz_en = 1'($urandom); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    wait_pos(2 * RD + BC);
    do_load(16'hBEEF, 4'hF, 4'hF, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (dut_vec() !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_values got=%h exp=%h", dut_vec(), {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
      end
    end
    reset = 1'b0;
    cyc = 0; found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (!found) cyc++;
      if (anodes === 4'b1110) found = 1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_model t=%0d got=%h exp=%h", m_t, dut_vec(), exp_vec());
      end
    end
    n_tests++;
    if (!found || cyc != 3) begin
      n_fail++;
      $display("FAIL reset_mid_restart got=%0d cycles exp=3", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_collision();
    test_blanking();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
